// File: rtl/page_selector_if.sv
// Button inputs and page-select outputs of the page selector, grouped as one port.
// Latency: none, wiring only.
// Backpressure: none; buttons are free-running levels and outputs are always valid.
interface page_selector_if #(
    parameter int NUM_PAGES = 4
) ();
    localparam int IDX_W = $clog2(NUM_PAGES);

    logic                 bt_next;
    logic                 bt_pre;
    logic                 bt_auto;
    logic [NUM_PAGES-1:0] enable_sw;
    logic [IDX_W-1:0]     page_idx;
    logic                 auto_on;

    // Board side drives the buttons and observes the selection.
    modport master (
        output bt_next, bt_pre, bt_auto,
        input  enable_sw, page_idx, auto_on
    );

    // Selector side consumes the buttons and produces the selection.
    modport slave (
        input  bt_next, bt_pre, bt_auto,
        output enable_sw, page_idx, auto_on
    );
endinterface

// File: rtl/page_selector.sv
// One-hot display-page selector driven by next/prev/auto-play buttons; optional debounce via `PAGE_SEL_DEBOUNCE_EN.
// Latency: index updates 2 sysclk edges after a button is first sampled high (plus DEBOUNCE_CYCLES when debounced).
// Backpressure: none; a held button yields one step, manual steps override and restart the auto timer.
module page_selector #(
    parameter int NUM_PAGES       = 4,
    parameter int AUTO_PERIOD     = 134217728,
    parameter int WRAP            = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic          sysclk,
    input logic          rst_n,
    page_selector_if.slave sel
);
    localparam int IDX_W = $clog2(NUM_PAGES);
    localparam int TMR_W = $clog2(AUTO_PERIOD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PAGES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

    if (NUM_PAGES < 2 || NUM_PAGES > 16 || AUTO_PERIOD < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("page_selector: parameter out of range");
    end

    // Button vectors are ordered {auto, pre, next}.
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       cond;
    logic [2:0]       cond_q;
    logic [2:0]       pulse;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;
    logic [TMR_W-1:0] tmr;
    logic             auto_on;
    logic             manual;
    logic             auto_step;

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sel.bt_auto, sel.bt_pre, sel.bt_next};
            sync2 <= sync1;
        end
    end

`ifdef PAGE_SEL_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      db_lvl;

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign cond = db_lvl;
`else
    assign cond = sync2;
`endif

    // Previous conditioned level for rising-edge detection.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) cond_q <= '0;
        else        cond_q <= cond;
    end

    assign pulse     = cond & ~cond_q;
    assign manual    = pulse[0] ^ pulse[1];
    assign auto_step = auto_on && (tmr == TMR_LAST) && !manual;

    // Neighbour indices with wrap or saturate at both range ends.
    always_comb begin
        idx_inc = idx + IDX_W'(1);
        idx_dec = idx - IDX_W'(1);
        if (idx == IDX_LAST) idx_inc = (WRAP != 0) ? '0 : IDX_LAST;
        if (idx == '0)       idx_dec = (WRAP != 0) ? IDX_LAST : '0;
    end

    // Page index, auto-play flag and auto-advance timer; manual steps take priority.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            auto_on <= 1'b0;
            tmr     <= '0;
        end else begin
            if (manual)         idx <= pulse[0] ? idx_inc : idx_dec;
            else if (auto_step) idx <= idx_inc;

            if (pulse[2]) auto_on <= ~auto_on;

            if (pulse[2] || manual) tmr <= '0;
            else if (auto_on)       tmr <= (tmr == TMR_LAST) ? '0 : tmr + TMR_W'(1);
        end
    end

    assign sel.enable_sw = {{(NUM_PAGES-1){1'b0}}, 1'b1} << idx;
    assign sel.page_idx  = idx;
    assign sel.auto_on   = auto_on;
endmodule

// File: doc/page_selector.md
# page_selector

Parametrised display-page selector for the plot-switching front end. It converts three raw push-buttons (next, previous, auto-play toggle) into a one-hot page enable across `NUM_PAGES` display sources. It adds input synchronisation, edge detection, a configurable auto-advance period and wrap/saturate selection. It sits between the board buttons and the plot multiplexer, replacing the fixed four-page selector.

## Interface
- `NUM_PAGES`, default 4: number of selectable pages, range 2..16.
- `AUTO_PERIOD`, default 134217728: auto-advance interval in `sysclk` cycles, minimum 2.
- `WRAP`, default 1: 1 = index wraps at both ends; 0 = index saturates at 0 and `NUM_PAGES-1`.
- `DEBOUNCE_CYCLES`, default 1000000: stable-level cycles required per button; used only with `PAGE_SEL_DEBOUNCE_EN`.
- `sysclk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Assertion is immediate; release is synchronous to `sysclk`.
- `bt_next`  in  1  raw next-page button, asynchronous, active-high.
- `bt_pre`  in  1  raw previous-page button, asynchronous, active-high.
- `bt_auto`  in  1  raw auto-play toggle button, asynchronous, active-high.
- `enable_sw`  out  NUM_PAGES  one-hot page enable; bit i is high when page i is selected.
- `page_idx`  out  $clog2(NUM_PAGES)  binary index of the current page.
- `auto_on`  out  1  auto-play state.

## Operation
- **Input conditioning:**
  - Each button passes through a two-flop synchroniser.
  - Optionally, the synchronised level then passes through a debouncer.
  - A registered previous-level copy gives a one-cycle press pulse on each 0→1 transition.
  - A held button produces exactly one pulse per press.
- **Step resolution:**
  - `next` pulse alone: index +1.
  - `pre` pulse alone: index −1.
  - `next` and `pre` pulses in the same cycle: no step.
- **Range rules:**
  - With `WRAP=1`: `NUM_PAGES-1`+1 → 0, and 0−1 → `NUM_PAGES-1`.
  - With `WRAP=0`: the index holds at the range ends.
  - The index never leaves 0..`NUM_PAGES-1`, including when `NUM_PAGES` is not a power of two.
- **Auto toggle:**
  - An `auto` pulse inverts `auto_on`.
  - It is independent of the step resolution and may coincide with a manual step; both take effect.
- **Auto timer:**
  - The timer is a counter of width $clog2(AUTO_PERIOD).
  - It counts 0..`AUTO_PERIOD-1` only while `auto_on`=1.
  - At terminal count it returns to 0 and issues one auto step (+1, using the same wrap/saturate rule).
  - It clears to 0 when `auto_on` toggles in either direction.
  - It clears to 0 on any cycle with an accepted manual step, and that cycle's auto step is suppressed. Manual input always wins.
- **Outputs:**
  - `enable_sw` is decoded combinationally from the registered index; exactly one bit is high at all times.
  - `page_idx` and `auto_on` are direct register outputs.
- **Reset values:**
  - Index 0, so `enable_sw` = 1 (one-hot bit 0) and `page_idx` = 0.
  - `auto_on` = 0, timer = 0.
  - Synchronisers, debouncers and edge registers all clear to 0.
  - A button held through reset release therefore registers one press once the synchroniser, and the debouncer when present, have propagated the high level.
  - Reset asserted mid-count discards the count.

## Timing
- **Without debounce:** a button sampled high at edge k propagates through synchroniser stage 2 by edge k+1. The pulse is asserted in the following cycle and the index/`enable_sw` update at edge k+2, two cycles after the sampling edge.
- **With debounce:** add `DEBOUNCE_CYCLES` cycles of stable level before the pulse.
- **Auto-advance:** one step every `AUTO_PERIOD` cycles exactly, measured from the cycle `auto_on` rose or from the last manual step.
- **Pulse spacing:** back-to-back presses are accepted if separated by at least one low sample after conditioning.

## Configuration
- **`PAGE_SEL_DEBOUNCE_EN` defined:**
  - Each synchronised button feeds a counter-based debouncer.
  - The debounced level changes only after the raw synchronised level differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any reversion within that window resets the counter.
- **`PAGE_SEL_DEBOUNCE_EN` undefined:**
  - The debouncer is absent, `DEBOUNCE_CYCLES` is ignored, and the synchronised level feeds edge detection directly.

## Test plan
- **Reset:** assert `rst_n`=0 mid-operation → `enable_sw`=0001, `page_idx`=0, `auto_on`=0 immediately, asynchronously.
- **Next with wrap:** `NUM_PAGES`=4, `WRAP`=1; 5 `bt_next` presses, each held 10 cycles → `page_idx` sequence 1,2,3,0,1, one step per press, each update 2 cycles after the sampling edge.
- **Previous with saturate:** `NUM_PAGES`=5, `WRAP`=0; from 0, press `bt_pre` → stays 0. Then press `bt_next` 6 times → ends at 4 and `enable_sw`=10000.
- **Simultaneous buttons:** `bt_next` and `bt_pre` rise on the same cycle → index unchanged. `bt_auto` and `bt_next` rise together → `auto_on`=1 and index +1.
- **Auto-advance:** `AUTO_PERIOD`=8; toggle auto on → steps every 8 cycles. A manual `bt_next` in the step cycle → single step, next auto step 8 cycles later. Toggle auto off → no further steps.
- **Debounce (`PAGE_SEL_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4):** 3-cycle glitch → no step. A 6-cycle press → one step.
